polar_dec_sequencer: RTL

- Leaf-level sequencer for the list-2 SC polar decoder.
- Walks leaf indices 0..N-1 of one codeword and drives the per-leaf control inputs of the path-decision stage: F, makeDec, copyEn, rstMetrics and pathCnt.
- Paces leaves off the LLR-tree valid strobe and waits out the decision pipeline latency before requesting the next leaf.
- Sits between the top-level decoder FSM (start/done) and the decision/metric stage.

---
 rtl/polar_dec_sequencer_if.sv | 33 +++
 rtl/polar_dec_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/polar_dec_sequencer_if.sv
// Control bundle between the leaf sequencer and its neighbours: the decoder FSM
// (start/abort/mask), the LLR tree (leafReq/llrValid) and the decision stage.
interface polar_dec_sequencer_if #(
    parameter int N    = 32,
    parameter int LOGN = 5
);
    logic            start;
    logic            abort;
    logic [N-1:0]    frznMask;
    logic            llrValid;
    logic [LOGN-1:0] leafIdx;
    logic            leafReq;
    logic            F;
    logic            makeDec;
    logic            copyEn;
    logic            rstMetrics;
    logic            pathCnt;
    logic            busy;
    logic            done;
    logic [LOGN:0]   infoCnt;

    modport master (
        output start, abort, frznMask, llrValid,
        input  leafIdx, leafReq, F, makeDec, copyEn, rstMetrics, pathCnt,
               busy, done, infoCnt
    );

    modport slave (
        input  start, abort, frznMask, llrValid,
        output leafIdx, leafReq, F, makeDec, copyEn, rstMetrics, pathCnt,
               busy, done, infoCnt
    );
endinterface

// File: rtl/polar_dec_sequencer.sv
// Leaf-level sequencer for a list-2 SC polar decoder: steps through leaves
// 0..N-1, pacing each off llrValid and waiting out the decision latency.
module polar_dec_sequencer #(
    parameter int N       = 32,
    parameter int LOGN    = 5,
    parameter int DEC_LAT = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enb,
    polar_dec_sequencer_if.slave    bus
);
    localparam int CW = (DEC_LAT > 1) ? $clog2(DEC_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_REQ    = 3'd2,
        S_DEC    = 3'd3,
        S_SETTLE = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    state_t          state_q;
    logic [N-1:0]    mask_q;
    logic [LOGN-1:0] leaf_q;
    logic [LOGN:0]   info_q;
    logic [CW-1:0]   cnt_q;
    logic            leaf_req_q;
    logic            f_q;
    logic            make_dec_q;
    logic            copy_en_q;
    logic            rst_metrics_q;
    logic            path_cnt_q;
    logic            busy_q;
    logic            done_q;

    logic [LOGN-1:0] leaf_nxt_d;
    logic            last_leaf_s;

    assign leaf_nxt_d  = leaf_q + LOGN'(1);
    assign last_leaf_s = (leaf_q == LOGN'(N - 1));

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            mask_q        <= '0;
            leaf_q        <= '0;
            info_q        <= '0;
            cnt_q         <= '0;
            leaf_req_q    <= 1'b0;
            f_q           <= 1'b0;
            make_dec_q    <= 1'b0;
            copy_en_q     <= 1'b0;
            rst_metrics_q <= 1'b0;
            path_cnt_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else if (enb) begin
            if (bus.abort) begin
                // The latched mask survives an abort; everything else clears.
                state_q       <= S_IDLE;
                leaf_q        <= '0;
                info_q        <= '0;
                cnt_q         <= '0;
                leaf_req_q    <= 1'b0;
                f_q           <= 1'b0;
                make_dec_q    <= 1'b0;
                copy_en_q     <= 1'b0;
                rst_metrics_q <= 1'b0;
                path_cnt_q    <= 1'b0;
                busy_q        <= 1'b0;
                done_q        <= 1'b0;
            end else begin
                make_dec_q    <= 1'b0;
                copy_en_q     <= 1'b0;
                rst_metrics_q <= 1'b0;
                done_q        <= 1'b0;
                case (state_q)
                    S_IDLE: begin
                        if (bus.start) begin
                            mask_q        <= bus.frznMask;
                            leaf_q        <= '0;
                            info_q        <= '0;
                            path_cnt_q    <= 1'b0;
                            busy_q        <= 1'b1;
                            rst_metrics_q <= 1'b1;
                            state_q       <= S_CLR;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_CLR: begin
                        leaf_req_q <= 1'b1;
                        f_q        <= ~mask_q[leaf_q];
                        state_q    <= S_REQ;
                    end
                    S_REQ: begin
                        if (bus.llrValid) begin
                            leaf_req_q <= 1'b0;
                            make_dec_q <= 1'b1;
                            copy_en_q  <= f_q & path_cnt_q;
                            info_q     <= f_q ? (info_q + (LOGN + 1)'(1)) : info_q;
                            state_q    <= S_DEC;
                        end else begin
                            state_q <= S_REQ;
                        end
                    end
                    S_DEC: begin
                        cnt_q   <= CW'(DEC_LAT - 1);
                        state_q <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (cnt_q == '0) begin
                            // First info bit splits the single path into two.
                            path_cnt_q <= path_cnt_q | f_q;
                            if (last_leaf_s) begin
                                done_q  <= 1'b1;
                                state_q <= S_FIN;
                            end else begin
                                leaf_q     <= leaf_nxt_d;
                                f_q        <= ~mask_q[leaf_nxt_d];
                                leaf_req_q <= 1'b1;
                                state_q    <= S_REQ;
                            end
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    S_FIN: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end else begin
            state_q <= state_q;
        end
    end

    assign bus.leafIdx    = leaf_q;
    assign bus.leafReq    = leaf_req_q;
    assign bus.F          = f_q;
    assign bus.makeDec    = make_dec_q;
    assign bus.copyEn     = copy_en_q;
    assign bus.rstMetrics = rst_metrics_q;
    assign bus.pathCnt    = path_cnt_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.infoCnt    = info_q;
endmodule
